// File: rtl/axi_lite_ctrl_responder.sv
// axi_lite_ctrl_responder
// AXI4-Lite slave that closes out an unused 32-bit shell control port.
// Offset 0x00 holds a read-only ID word. Offsets 0x04..0x3C are fifteen
// read/write scratch words. Any address with bits [31:6] nonzero gets DECERR,
// and every DECERR is added to a saturating 16-bit counter.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. Once valid is raised, the source holds it and its payload until
// that edge. Every ready here comes from a register, and every response
// output is registered, so no input reaches an output in the same cycle.
//
// dbg_state = {write_state, read_state, aw_captured, w_captured}.
module axi_lite_ctrl_responder #(
  parameter logic [31:0] ID_VALUE = 32'hF1E5_0001,
  parameter int unsigned FREQ_HZ  = 175000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] S_AXI_CTRL_0_awaddr,
  input  logic        S_AXI_CTRL_0_awvalid,
  output logic        S_AXI_CTRL_0_awready,
  input  logic [31:0] S_AXI_CTRL_0_wdata,
  input  logic        S_AXI_CTRL_0_wvalid,
  output logic        S_AXI_CTRL_0_wready,
  output logic [1:0]  S_AXI_CTRL_0_bresp,
  output logic        S_AXI_CTRL_0_bvalid,
  input  logic        S_AXI_CTRL_0_bready,
  input  logic [31:0] S_AXI_CTRL_0_araddr,
  input  logic        S_AXI_CTRL_0_arvalid,
  output logic        S_AXI_CTRL_0_arready,
  output logic [31:0] S_AXI_CTRL_0_rdata,
  output logic [1:0]  S_AXI_CTRL_0_rresp,
  output logic        S_AXI_CTRL_0_rvalid,
  input  logic        S_AXI_CTRL_0_rready,
  output logic [15:0] decerr_count,
  output logic [3:0]  dbg_state
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The clock frequency is only carried along for the interface annotation.
  localparam int unsigned unused_freq_hz = FREQ_HZ;

  typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_t;
  typedef enum logic { R_IDLE = 1'b0, R_RESP = 1'b1 } r_state_t;

  // ---------------------------------------------------------------------------
  // Register file. Entry 0 is never written, because the ID word is a constant.
  // ---------------------------------------------------------------------------
  logic [31:0] r_scratch [16];

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t    r_wstate;
  w_state_t    w_wstate_nxt;
  logic        r_aw_got;
  logic        r_w_got;
  logic [31:2] r_awaddr;
  logic [31:0] r_wdata;
  logic [1:0]  r_bresp;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_have_aw;
  logic        w_have_w;
  logic        w_wr_commit;
  logic [31:2] w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_wr_mapped;
  logic [3:0]  w_wr_idx;

  assign S_AXI_CTRL_0_awready = (r_wstate == W_IDLE) && !r_aw_got;
  assign S_AXI_CTRL_0_wready  = (r_wstate == W_IDLE) && !r_w_got;
  assign S_AXI_CTRL_0_bvalid  = (r_wstate == W_RESP);
  assign S_AXI_CTRL_0_bresp   = r_bresp;

  assign w_aw_hs   = S_AXI_CTRL_0_awvalid && S_AXI_CTRL_0_awready;
  assign w_w_hs    = S_AXI_CTRL_0_wvalid  && S_AXI_CTRL_0_wready;
  assign w_have_aw = r_aw_got || w_aw_hs;
  assign w_have_w  = r_w_got  || w_w_hs;

  // Commit happens on the edge where the second of AW and W arrives.
  // AW and W can also arrive on the same edge.
  assign w_wr_commit = (r_wstate == W_IDLE) && w_have_aw && w_have_w;
  assign w_wr_addr   = r_aw_got ? r_awaddr : S_AXI_CTRL_0_awaddr[31:2];
  assign w_wr_data   = r_w_got  ? r_wdata  : S_AXI_CTRL_0_wdata;
  assign w_wr_mapped = (w_wr_addr[31:6] == 26'd0);
  assign w_wr_idx    = w_wr_addr[5:2];

  // Write FSM next state: go to RESP on commit, and back to IDLE on the B handshake.
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (S_AXI_CTRL_0_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  // Hold whichever of AW/W arrives first until its partner arrives.
  // Reset discards anything half captured.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
    end else if (w_wr_commit) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= S_AXI_CTRL_0_awaddr[31:2];
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= S_AXI_CTRL_0_wdata;
      end
    end
  end

  // Write response is registered at commit and held until the B handshake.
  always_ff @(posedge clock) begin
    if (reset)            r_bresp <= RESP_OKAY;
    else if (w_wr_commit) r_bresp <= w_wr_mapped ? RESP_OKAY : RESP_DECERR;
  end

  // Scratch update. ID writes and unmapped writes leave the file untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_scratch[i] <= '0;
    end else if (w_wr_commit && w_wr_mapped && (w_wr_idx != 4'd0)) begin
      r_scratch[w_wr_idx] <= w_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t    r_rstate;
  r_state_t    w_rstate_nxt;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_ar_hs;
  logic        w_rd_mapped;
  logic [3:0]  w_rd_idx;
  logic [31:0] w_rd_word;

  assign S_AXI_CTRL_0_arready = (r_rstate == R_IDLE);
  assign S_AXI_CTRL_0_rvalid  = (r_rstate == R_RESP);
  assign S_AXI_CTRL_0_rdata   = r_rdata;
  assign S_AXI_CTRL_0_rresp   = r_rresp;

  assign w_ar_hs     = S_AXI_CTRL_0_arvalid && S_AXI_CTRL_0_arready;
  assign w_rd_mapped = (S_AXI_CTRL_0_araddr[31:6] == 26'd0);
  assign w_rd_idx    = S_AXI_CTRL_0_araddr[5:2];

  // Read mux. It reads the current register contents, so a write that commits
  // on the same edge is not visible to this read.
  always_comb begin
    w_rd_word = 32'd0;
    if (w_rd_mapped) begin
      if (w_rd_idx == 4'd0) w_rd_word = ID_VALUE;
      else                  w_rd_word = r_scratch[w_rd_idx];
    end
  end

  // Read FSM next state: go to RESP on the AR handshake, and back to IDLE on the R handshake.
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP:  if (S_AXI_CTRL_0_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Read data and response are registered at AR acceptance and held until the R handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_word;
      r_rresp <= w_rd_mapped ? RESP_OKAY : RESP_DECERR;
    end
  end

  // ---------------------------------------------------------------------------
  // DECERR counter. A read error and a write error on the same edge add 2.
  // The counter saturates at all ones.
  // ---------------------------------------------------------------------------
  logic [15:0] r_decerr_cnt;
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;

  assign w_err_inc = {1'b0, (w_wr_commit && !w_wr_mapped)} +
                     {1'b0, (w_ar_hs && !w_rd_mapped)};
  assign w_err_sum = {1'b0, r_decerr_cnt} + {15'd0, w_err_inc};

  // Saturating accumulate.
  always_ff @(posedge clock) begin
    if (reset)             r_decerr_cnt <= '0;
    else if (w_err_sum[16]) r_decerr_cnt <= 16'hFFFF;
    else                   r_decerr_cnt <= w_err_sum[15:0];
  end

  assign decerr_count = r_decerr_cnt;
  assign dbg_state    = {r_wstate, r_rstate, r_aw_got, r_w_got};

  // The byte-offset bits of both addresses are ignored.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{S_AXI_CTRL_0_awaddr[1:0], S_AXI_CTRL_0_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_ctrl_responder.sv
// Directed bench for axi_lite_ctrl_responder.
// Inputs change 1 ns after each rising edge, and outputs are sampled at the same point.
module tb_axi_lite_ctrl_responder;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] awaddr  = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata   = '0;
  logic        wvalid  = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready  = 1'b0;
  logic [31:0] araddr  = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready  = 1'b0;
  logic [15:0] decerr_count;
  logic [3:0]  dbg_state;

  axi_lite_ctrl_responder dut (
    .clock                (clock),
    .reset                (reset),
    .S_AXI_CTRL_0_awaddr  (awaddr),
    .S_AXI_CTRL_0_awvalid (awvalid),
    .S_AXI_CTRL_0_awready (awready),
    .S_AXI_CTRL_0_wdata   (wdata),
    .S_AXI_CTRL_0_wvalid  (wvalid),
    .S_AXI_CTRL_0_wready  (wready),
    .S_AXI_CTRL_0_bresp   (bresp),
    .S_AXI_CTRL_0_bvalid  (bvalid),
    .S_AXI_CTRL_0_bready  (bready),
    .S_AXI_CTRL_0_araddr  (araddr),
    .S_AXI_CTRL_0_arvalid (arvalid),
    .S_AXI_CTRL_0_arready (arready),
    .S_AXI_CTRL_0_rdata   (rdata),
    .S_AXI_CTRL_0_rresp   (rresp),
    .S_AXI_CTRL_0_rvalid  (rvalid),
    .S_AXI_CTRL_0_rready  (rready),
    .decerr_count         (decerr_count),
    .dbg_state            (dbg_state)
  );

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Single write with AW and W together. It checks that B arrives one cycle
  // after the handshake and that the readies recover after the B handshake.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    chk("wr_awready_idle", {31'd0, awready}, 32'd1);
    chk("wr_wready_idle",  {31'd0, wready},  32'd1);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid_latency", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("wr_bvalid_clear", {31'd0, bvalid},  32'd0);
    chk("wr_awready_back", {31'd0, awready}, 32'd1);
  endtask

  // Single read. It checks that R arrives one cycle after the AR handshake.
  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    chk("rd_arready_idle", {31'd0, arready}, 32'd1);
    araddr = addr; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rd_rvalid_latency", {31'd0, rvalid}, 32'd1);
    data = rdata;
    resp = rresp;
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rd_rvalid_clear", {31'd0, rvalid},  32'd0);
    chk("rd_arready_back", {31'd0, arready}, 32'd1);
  endtask

  // ---------------- scoreboard / stimulus ----------------
  localparam logic [31:0] ID = 32'hF1E5_0001;
  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready",  {31'd0, wready},  32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    chk("rst_rresp",   {30'd0, rresp},   32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_decerr",  {16'd0, decerr_count}, 32'd0);
    chk("rst_dbg",     {28'd0, dbg_state},    32'd0);
    reset = 1'b0;
    step();

    // ID read
    rd(32'h00, d, r);
    chk("id_rdata", d, ID);
    chk("id_rresp", {30'd0, r}, 32'd0);

    // Write with AW and W in the same cycle, then read it back
    wr(32'h08, 32'hA5A5_5A5A, r);
    chk("w08_bresp", {30'd0, r}, 32'd0);
    rd(32'h08, d, r);
    chk("r08_data", d, 32'hA5A5_5A5A);
    chk("r08_resp", {30'd0, r}, 32'd0);
    rd(32'h04, d, r);
    chk("r04_zero", d, 32'd0);
    rd(32'h3C, d, r);
    chk("r3c_zero", d, 32'd0);

    // W three cycles ahead of AW
    wdata = 32'h1234_5678; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("wfirst_wready_drop",  {31'd0, wready},  32'd0);
    chk("wfirst_awready_hold", {31'd0, awready}, 32'd1);
    chk("wfirst_no_bvalid",    {31'd0, bvalid},  32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("wfirst_wait_wready", {31'd0, wready}, 32'd0);
      chk("wfirst_wait_bvalid", {31'd0, bvalid}, 32'd0);
    end
    awaddr = 32'h3C; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
    chk("wfirst_bresp",  {30'd0, bresp},  32'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    rd(32'h3C, d, r);
    chk("r3c_data", d, 32'h1234_5678);

    // Unmapped write and unmapped read in the same cycle, then stall both responses
    awaddr = 32'h40; wdata = 32'hDEAD_0040; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h1000; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("err_decerr2", {16'd0, decerr_count}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      chk("hold_bvalid",  {31'd0, bvalid},  32'd1);
      chk("hold_rvalid",  {31'd0, rvalid},  32'd1);
      chk("hold_bresp",   {30'd0, bresp},   32'd3);
      chk("hold_rresp",   {30'd0, rresp},   32'd3);
      chk("hold_rdata",   rdata,            32'd0);
      chk("hold_awready", {31'd0, awready}, 32'd0);
      chk("hold_wready",  {31'd0, wready},  32'd0);
      chk("hold_arready", {31'd0, arready}, 32'd0);
      step();
    end
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    chk("rel_awready", {31'd0, awready}, 32'd1);
    chk("rel_wready",  {31'd0, wready},  32'd1);
    chk("rel_arready", {31'd0, arready}, 32'd1);
    chk("rel_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rel_rvalid",  {31'd0, rvalid},  32'd0);
    // An unmapped write that aliases index 2 in its low bits
    wr(32'h0000_1008, 32'hBAD0_BAD0, r);
    chk("w1008_decerr", {30'd0, r}, 32'd3);
    chk("err_decerr3", {16'd0, decerr_count}, 32'd3);
    rd(32'h08, d, r);
    chk("unch_08", d, 32'hA5A5_5A5A);
    rd(32'h3C, d, r);
    chk("unch_3c", d, 32'h1234_5678);
    rd(32'h04, d, r);
    chk("unch_04", d, 32'd0);

    // A write to ID returns OKAY and has no effect; address bits [1:0] are ignored
    wr(32'h00, 32'hDEAD_BEEF, r);
    chk("wid_okay", {30'd0, r}, 32'd0);
    rd(32'h03, d, r);
    chk("wid_noeffect", d, ID);
    rd(32'h0B, d, r);
    chk("lsb_ignored", d, 32'hA5A5_5A5A);
    chk("err_decerr_same", {16'd0, decerr_count}, 32'd3);

    // Read and write of the same index in the same cycle return the old value
    awaddr = 32'h0C; wdata = 32'h0BAD_F00D; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("rw_same_bvalid", {31'd0, bvalid}, 32'd1);
    chk("rw_same_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rw_same_old",    rdata,           32'd0);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    rd(32'h0C, d, r);
    chk("rw_same_new", d, 32'h0BAD_F00D);

    // Reset pulse while bvalid is 1
    awaddr = 32'h04; wdata = 32'hFFFF_FFFF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rstmid_bvalid_pre", {31'd0, bvalid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rstmid_awready", {31'd0, awready}, 32'd1);
    chk("rstmid_decerr",  {16'd0, decerr_count}, 32'd0);
    step();
    chk("rstmid_no_resp", {31'd0, bvalid}, 32'd0);
    rd(32'h04, d, r);
    chk("rstmid_r04", d, 32'd0);
    rd(32'h08, d, r);
    chk("rstmid_r08", d, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
